// File: rtl/sysid_boot_checker.sv
// Boot-time system-ID checker: Avalon-MM master that reads the sysid ID/timestamp words and publishes a sticky verdict.
// Optional read watchdog enabled by defining SYSID_CHECK_TIMEOUT_EN.
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1577004102,
  parameter int unsigned MAX_RETRIES        = 2,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  if (MAX_RETRIES > 7 || TIMEOUT_CYCLES < 1) begin : g_param_err
    $error("sysid_boot_checker: MAX_RETRIES must be 0..7 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, CMP, DONE} state_t;

  state_t     state, state_d;
  logic [2:0] retry_cnt;
  logic       autostart;
  logic       check_start, retry, cap_id, cap_ts, to_hit, to_expire;
  logic       id_match, ts_match;

  assign id_match = (id_value == EXPECTED_ID);
  assign ts_match = (ts_value == EXPECTED_TIMESTAMP);
  assign pass     = done & id_ok & ts_ok;

`ifdef SYSID_CHECK_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] wait_cnt;

  assign to_expire = avm_waitrequest && (wait_cnt == TO_LAST);

  // Any state change starts a fresh read (or ends one), so the count restarts.
  always_ff @(posedge clock) begin
    if (reset || state_d != state) wait_cnt <= '0;
    else if (avm_read && avm_waitrequest) wait_cnt <= wait_cnt + 1'b1;
  end
`else
  assign to_expire = 1'b0;
`endif

  always_comb begin
    state_d     = state;
    avm_read    = 1'b0;
    avm_address = 1'b0;
    busy        = 1'b0;
    check_start = 1'b0;
    retry       = 1'b0;
    cap_id      = 1'b0;
    cap_ts      = 1'b0;
    to_hit      = 1'b0;
    case (state)
      IDLE: if (autostart || start) begin
        state_d     = RD_ID;
        check_start = 1'b1;
      end
      RD_ID: begin
        avm_read = 1'b1;
        busy     = 1'b1;
        if (!avm_waitrequest) begin
          cap_id  = 1'b1;
          state_d = RD_TS;
        end else if (to_expire) begin
          to_hit  = 1'b1;
          state_d = DONE;
        end
      end
      RD_TS: begin
        avm_read    = 1'b1;
        avm_address = 1'b1;
        busy        = 1'b1;
        if (!avm_waitrequest) begin
          cap_ts  = 1'b1;
          state_d = CMP;
        end else if (to_expire) begin
          to_hit  = 1'b1;
          state_d = DONE;
        end
      end
      CMP: begin
        busy = 1'b1;
        if (id_match && ts_match) state_d = DONE;
        else if (retry_cnt < 3'(MAX_RETRIES)) begin
          retry   = 1'b1;
          state_d = RD_ID;
        end else state_d = DONE;
      end
      DONE: if (start) begin
        state_d     = RD_ID;
        check_start = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      retry_cnt <= '0;
      autostart <= 1'b1;
      done      <= 1'b0;
      id_ok     <= 1'b0;
      ts_ok     <= 1'b0;
      timeout   <= 1'b0;
      id_value  <= '0;
      ts_value  <= '0;
    end else begin
      state <= state_d;
      if (check_start) begin
        autostart <= 1'b0;
        done      <= 1'b0;
        id_ok     <= 1'b0;
        ts_ok     <= 1'b0;
        timeout   <= 1'b0;
        if (start) retry_cnt <= '0;
      end
      if (retry) retry_cnt <= retry_cnt + 3'd1;
      if (cap_id) id_value <= avm_readdata;
      if (cap_ts) ts_value <= avm_readdata;
      if (state == CMP) begin
        id_ok <= id_match;
        ts_ok <= ts_match;
      end
      if (to_hit) begin
        timeout <= 1'b1;
        id_ok   <= 1'b0;
        ts_ok   <= 1'b0;
      end
      if (state_d == DONE && state != DONE) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Bench for sysid_boot_checker: slave model with programmable data/stalls, address scoreboard and verdict checks.
module tb_sysid_boot_checker;
  localparam logic [31:0] TS_GOOD = 32'd1577004102;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        avm_address, avm_read, avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy, done, id_ok, ts_ok, pass, timeout;
  logic [31:0] id_value, ts_value;

  logic [31:0] id_data = 32'd0;
  logic [31:0] ts_data = TS_GOOD;
  int          stall_id = 0;
  logic        stuck = 1'b0;
  int          wcnt = 0;
  int          checks = 0, failures = 0;
  logic        sb_q[$];

  always #5 clock = ~clock;

  sysid_boot_checker #(.TIMEOUT_CYCLES(10)) dut (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok), .pass(pass),
    .timeout(timeout), .id_value(id_value), .ts_value(ts_value)
  );

  // Slave model: stalls the ID read for stall_id cycles, or forever when stuck.
  always_comb begin
    avm_readdata    = avm_address ? ts_data : id_data;
    avm_waitrequest = avm_read && (stuck || (!avm_address && wcnt < stall_id));
  end
  always @(posedge clock) wcnt <= (avm_read && avm_waitrequest) ? wcnt + 1 : 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  // Scoreboard: every accepted read must match the next expected address.
  always @(negedge clock) begin
    if (!reset && avm_read && !avm_waitrequest) begin
      if (sb_q.size() == 0) chk("extra_read", 32'(avm_address), 32'hFFFF);
      else chk("rd_addr", 32'(avm_address), 32'(sb_q.pop_front()));
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    edges(2);
    chk("rst_read", 32'(avm_read), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_idv", id_value, 0);
    reset = 1'b0;
  endtask

  task automatic push_pairs(input int n);
    for (int i = 0; i < n; i++) begin
      sb_q.push_back(1'b0);
      sb_q.push_back(1'b1);
    end
  endtask

  task automatic wait_done(input string tag, input int limit);
    int k = 0;
    while (!done && k < limit) begin
      edges(1);
      k++;
    end
    chk(tag, 32'(done), 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    edges(1);
    start = 1'b0;
  endtask

  initial begin
    // 1: autostart, matching data, done on 4th edge
    do_reset();
    push_pairs(1);
    edges(3);
    chk("t1_done_e3", 32'(done), 0);
    chk("t1_busy_e3", 32'(busy), 1);
    edges(1);
    chk("t1_done_e4", 32'(done), 1);
    chk("t1_pass", 32'(pass), 1);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_read", 32'(avm_read), 0);
    chk("t1_tsv", ts_value, TS_GOOD);

    // 2: bad timestamp, retries exhausted after 3 passes
    ts_data = TS_GOOD + 1;
    do_reset();
    push_pairs(3);
    wait_done("t2_done", 40);
    chk("t2_idok", 32'(id_ok), 1);
    chk("t2_tsok", 32'(ts_ok), 0);
    chk("t2_pass", 32'(pass), 0);
    chk("t2_tsv", ts_value, TS_GOOD + 1);
    chk("t2_sb", sb_q.size(), 0);
    ts_data = TS_GOOD;

    // 3: 5 stall cycles on the ID read -> done 5 cycles later
    stall_id = 5;
    do_reset();
    push_pairs(1);
    edges(1);
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall_rd", {avm_read, avm_address, avm_waitrequest}, 3'b101);
      edges(1);
    end
    edges(2);
    chk("t3_done_e8", 32'(done), 0);
    edges(1);
    chk("t3_done_e9", 32'(done), 1);
    chk("t3_pass", 32'(pass), 1);
    stall_id = 0;

    // 4: start in DONE reruns; start while busy is ignored
    push_pairs(1);
    pulse_start();
    chk("t4_done_clr", 32'(done), 0);
    chk("t4_busy", 32'(busy), 1);
    pulse_start();
    wait_done("t4_done", 10);
    edges(6);
    chk("t4_pass", 32'(pass), 1);
    chk("t4_idle_busy", 32'(busy), 0);
    chk("t4_sb", sb_q.size(), 0);

    // 5: reset during RD_TS aborts, then autostart reruns
    do_reset();
    sb_q.push_back(1'b0);
    edges(2);
    chk("t5_in_ts", {avm_read, avm_address}, 2'b11);
    reset = 1'b1;
    edges(1);
    chk("t5_read", 32'(avm_read), 0);
    chk("t5_idv", id_value, 0);
    chk("t5_busy", 32'(busy), 0);
    reset = 1'b0;
    push_pairs(1);
    wait_done("t5_done", 10);
    chk("t5_pass", 32'(pass), 1);

    // 6: waitrequest stuck high
    stuck = 1'b1;
    do_reset();
`ifdef SYSID_CHECK_TIMEOUT_EN
    edges(10);
    chk("t6_done_e10", 32'(done), 0);
    edges(1);
    chk("t6_done", 32'(done), 1);
    chk("t6_timeout", 32'(timeout), 1);
    chk("t6_pass", 32'(pass), 0);
    chk("t6_read", 32'(avm_read), 0);
`else
    edges(300);
    chk("t6_busy", 32'(busy), 1);
    chk("t6_done", 32'(done), 0);
    chk("t6_timeout", 32'(timeout), 0);
`endif
    stuck = 1'b0;
    chk("sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
